// File: rtl/braille_rotor_pkg.sv
// Shared definitions for the braille rotor angle path.
// Holds the line geometry defaults (rotor count, faces per rotor, angle word
// width), the face/index/angle types, the sequencer state enum and the
// face-to-angle conversion used by the transmit side.
package braille_rotor_pkg;

  localparam int NUM_ROTORS  = 32;
  localparam int FACES       = 8;
  localparam int ANGLE_W     = 8;
  localparam int IDX_W       = $clog2(NUM_ROTORS);
  localparam int FACE_W      = $clog2(FACES);
  localparam int ANGLE_STEP  = (2 ** ANGLE_W) / FACES;
  localparam int ANGLE_SHIFT = $clog2(ANGLE_STEP);

  typedef logic [FACE_W-1:0]  face_t;
  typedef logic [IDX_W-1:0]   idx_t;
  typedef logic [ANGLE_W-1:0] angle_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_SEND,
    ST_SETTLE,
    ST_DONE
  } state_t;

  // FACES is a power of two, so face * ANGLE_STEP is a plain left shift and
  // the largest face still fits in ANGLE_W bits.
  function automatic angle_t angle_of(face_t face);
    return angle_t'(face) << ANGLE_SHIFT;
  endfunction

endpackage

// File: rtl/braille_angle_sequencer_if.sv
// Angle word channel from the sequencer to the motor driver.
// Ports (signals):
//   angle_data  - angle word for the addressed rotor
//   rotor_idx   - rotor addressed by angle_data
//   angle_valid - transfer offered by the sequencer
//   angle_ready - receiver accepts the offered word
// Modports: master (sequencer side), slave (motor driver side).
interface braille_angle_sequencer_if;
  import braille_rotor_pkg::*;

  angle_t angle_data;
  idx_t   rotor_idx;
  logic   angle_valid;
  logic   angle_ready;

  modport master (
    output angle_data,
    output rotor_idx,
    output angle_valid,
    input  angle_ready
  );

  modport slave (
    input  angle_data,
    input  rotor_idx,
    input  angle_valid,
    output angle_ready
  );

endinterface

// File: rtl/braille_face_store.sv
// Per-rotor face storage for the angle sequencer.
// shadow    - target faces written by the front end at any time
// snap      - frozen copy of shadow taken at frame start
// committed - last face actually delivered to each rotor
// Ports:
//   clk, reset               - clock, asynchronous active-high reset
//   wr_en, wr_addr, wr_face  - shadow write port (out-of-range index ignored)
//   snap_en                  - copy the whole shadow array into snap
//   commit_en, commit_idx,
//   commit_face              - update one committed entry
//   rd_idx                   - registered rotor index from the sequencer
//   snap_rd, committed_rd    - snap[rd_idx] and committed[rd_idx]
module braille_face_store
  import braille_rotor_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  wr_en,
  input  idx_t  wr_addr,
  input  face_t wr_face,
  input  logic  snap_en,
  input  logic  commit_en,
  input  idx_t  commit_idx,
  input  face_t commit_face,
  input  idx_t  rd_idx,
  output face_t snap_rd,
  output face_t committed_rd
);

  face_t shadow    [NUM_ROTORS];
  face_t snap      [NUM_ROTORS];
  face_t committed [NUM_ROTORS];

  // Decoding the write address against each real entry means indices past
  // NUM_ROTORS simply match nothing. The snapshot copies the pre-edge shadow,
  // so a write in the same cycle as snap_en lands in shadow only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_ROTORS; k++) begin
        shadow[k]    <= '0;
        snap[k]      <= '0;
        committed[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_ROTORS; k++) begin
        if (wr_en && (wr_addr == idx_t'(k))) shadow[k] <= wr_face;
        if (snap_en) snap[k] <= shadow[k];
        if (commit_en && (commit_idx == idx_t'(k))) committed[k] <= commit_face;
      end
    end
  end

  assign snap_rd      = snap[rd_idx];
  assign committed_rd = committed[rd_idx];

endmodule

// File: rtl/braille_angle_sequencer.sv
// Transmit side of the rotor angle interface.
// On start, freezes the target faces and walks every rotor, sending one
// angle word for each rotor whose target differs from its last delivered
// face (or every rotor when forced), with a settle gap after each transfer.
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   wr_en/wr_addr/wr_face - target face write into the shadow store
//   start, force_all    - begin a frame (IDLE only); force resend of all rotors
//   busy                - frame in progress
//   done                - one-cycle pulse at frame end
//   sent_count          - transfers accepted in the current/last frame
//   angle_bus           - angle word channel (master side)
module braille_angle_sequencer
  import braille_rotor_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  idx_t               wr_addr,
  input  face_t              wr_face,
  input  logic               start,
  input  logic               force_all,
  output logic               busy,
  output logic               done,
  output logic [IDX_W:0]     sent_count,
  braille_angle_sequencer_if.master angle_bus
);

  // At least one bit even when the settle gap is disabled.
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_t           state_q;
  state_t           next_state;
  idx_t             idx_q;
  logic             force_q;
  logic [SET_W-1:0] settle_cnt;
  angle_t           angle_data_q;
  idx_t             rotor_idx_q;
  logic             valid_q;

  face_t snap_rd;
  face_t committed_rd;
  logic  snap_en;
  logic  commit_en;
  logic  load_out;
  logic  inc_idx;
  logic  advance;
  logic  last_rotor;
  logic  settle_done;

  braille_face_store u_store (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_face      (wr_face),
    .snap_en      (snap_en),
    .commit_en    (commit_en),
    .commit_idx   (idx_q),
    .commit_face  (snap_rd),
    .rd_idx       (idx_q),
    .snap_rd      (snap_rd),
    .committed_rd (committed_rd)
  );

  assign last_rotor  = (idx_q == idx_t'(NUM_ROTORS - 1));
  assign settle_done = (settle_cnt == SET_W'(SETTLE_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= next_state;
  end

  // Next-state and datapath strobes. "advance" folds the shared
  // end-of-rotor decision used by both SEND (no settle gap) and SETTLE.
  always_comb begin
    next_state = state_q;
    snap_en    = 1'b0;
    commit_en  = 1'b0;
    load_out   = 1'b0;
    inc_idx    = 1'b0;
    advance    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          snap_en    = 1'b1;
          next_state = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (force_q || (snap_rd != committed_rd)) begin
          load_out   = 1'b1;
          next_state = ST_SEND;
        end else if (last_rotor) begin
          next_state = ST_DONE;
        end else begin
          inc_idx = 1'b1;
        end
      end
      ST_SEND: begin
        if (valid_q && angle_bus.angle_ready) begin
          commit_en = 1'b1;
          if (SETTLE_CYCLES > 0) next_state = ST_SETTLE;
          else                   advance    = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (settle_done) advance = 1'b1;
      end
      ST_DONE: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
    if (advance) begin
      if (last_rotor) begin
        next_state = ST_DONE;
      end else begin
        inc_idx    = 1'b1;
        next_state = ST_SCAN;
      end
    end
  end

  // Output words are captured when leaving SCAN and then frozen, so they
  // stay stable for as long as the receiver stalls. valid follows the
  // registered next state and never sees angle_ready combinationally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q        <= '0;
      force_q      <= 1'b0;
      sent_count   <= '0;
      settle_cnt   <= '0;
      angle_data_q <= '0;
      rotor_idx_q  <= '0;
      valid_q      <= 1'b0;
    end else begin
      if (snap_en) begin
        idx_q      <= '0;
        force_q    <= force_all;
        sent_count <= '0;
      end else begin
        if (inc_idx)   idx_q      <= idx_q + 1'b1;
        if (commit_en) sent_count <= sent_count + 1'b1;
      end
      settle_cnt <= (state_q == ST_SETTLE) ? settle_cnt + 1'b1 : '0;
      if (load_out) begin
        angle_data_q <= angle_of(snap_rd);
        rotor_idx_q  <= idx_q;
      end
      valid_q <= (next_state == ST_SEND);
    end
  end

  assign angle_bus.angle_data  = angle_data_q;
  assign angle_bus.rotor_idx   = rotor_idx_q;
  assign angle_bus.angle_valid = valid_q;
  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);

endmodule
